// File: rtl/sample_ram_buffer.sv
// sample_ram_buffer
// Circular first-word-fall-through sample buffer. It picks one channel of the
// I2S sample stream, stores samples in an inferred block RAM with a
// registered read, and serves them in FIFO order on a valid/ready port.
// A hysteresis flag signals to the consumer that a batch is available.
//
// Ports:
//   clk_i              system clock
//   rst_i              asynchronous, active-high reset
//   sample_valid_i     one-cycle strobe: selected channel sample offered
//   left_sample_i      left-channel sample (signed, DATA_W bits)
//   right_sample_i     right-channel sample (signed, DATA_W bits)
//   ovf_clr_i          clears the sticky overflow flag
//   ram_read_data_o    head-of-queue sample
//   ram_read_valid_o   ram_read_data_o holds a valid sample
//   ram_read_ready_i   consumer accepts the sample
//   ram_buffer_ready_o batch available (sets at READY_LEVEL, clears at empty)
//   fill_o             samples held, including the output register
//   overflow_o         sticky: a sample was dropped because the buffer was full
module sample_ram_buffer #(
  parameter int   DATA_W      = 24,
  parameter int   DEPTH       = 512,
  parameter int   READY_LEVEL = 256,
  parameter logic SELECT_LEFT = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  input  logic [DATA_W-1:0]        left_sample_i,
  input  logic [DATA_W-1:0]        right_sample_i,
  input  logic                     ovf_clr_i,
  output logic [DATA_W-1:0]        ram_read_data_o,
  output logic                     ram_read_valid_o,
  input  logic                     ram_read_ready_i,
  output logic                     ram_buffer_ready_o,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     overflow_o
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_DEPTH = DEPTH - 1;

  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(RAM_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] FILL_MAX   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FILL_READY = CNT_W'(READY_LEVEL);

  // Pointers wrap at the RAM depth (DEPTH-1), which is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] r;
    if (p == PTR_LAST) begin
      r = PTR_ZERO;
    end else begin
      r = p + PTR_ONE;
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  ram_count;   // words still in the RAM array
  logic [DATA_W-1:0] ram_q;       // registered RAM read data
  logic              ram_q_valid; // a word is in flight in ram_q
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [CNT_W-1:0]  fill;
  logic              batch_ready;
  logic              overflow;

  logic [DATA_W-1:0] sel_sample;
  logic              wr_accept;
  logic              wr_drop;
  logic              rd_xfer;
  logic              out_load;
  logic              ram_rd_en;
  logic [CNT_W-1:0]  fill_next;
  logic [CNT_W-1:0]  ram_count_next;
  logic              batch_ready_next;

  // Handshake decode, pipeline advance and next-state counters.
  always_comb begin
    sel_sample       = SELECT_LEFT ? left_sample_i : right_sample_i;
    // Space is judged on the fill before this edge; a same-edge read does not help.
    wr_accept        = sample_valid_i && (fill < FILL_MAX);
    wr_drop          = sample_valid_i && !(fill < FILL_MAX);
    rd_xfer          = out_valid && ram_read_ready_i;
    // The output register refills from the read stage whenever it empties this edge.
    out_load         = ram_q_valid && (!out_valid || rd_xfer);
    // Issue a RAM read only if the read stage will be free after this edge.
    ram_rd_en        = (ram_count != CNT_ZERO) && (!ram_q_valid || out_load);
    fill_next        = fill;
    ram_count_next   = ram_count;
    batch_ready_next = batch_ready;
    case ({wr_accept, rd_xfer})
      2'b10:   fill_next = fill + CNT_ONE;
      2'b01:   fill_next = fill - CNT_ONE;
      default: fill_next = fill;
    endcase
    case ({wr_accept, ram_rd_en})
      2'b10:   ram_count_next = ram_count + CNT_ONE;
      2'b01:   ram_count_next = ram_count - CNT_ONE;
      default: ram_count_next = ram_count;
    endcase
    if (fill_next >= FILL_READY) begin
      batch_ready_next = 1'b1;
    end else if (fill_next == CNT_ZERO) begin
      batch_ready_next = 1'b0;
    end else begin
      batch_ready_next = batch_ready;
    end
  end

  // Sample storage: write port plus registered read port, no reset so it maps to block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem[wr_ptr] <= sel_sample;
    end
    if (ram_rd_en) begin
      ram_q <= mem[rd_ptr];
    end
  end

  // Pointers, RAM occupancy and the read-stage valid bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr      <= PTR_ZERO;
      rd_ptr      <= PTR_ZERO;
      ram_count   <= CNT_ZERO;
      ram_q_valid <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (ram_rd_en) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      ram_count <= ram_count_next;
      if (ram_rd_en) begin
        ram_q_valid <= 1'b1;
      end else if (out_load) begin
        ram_q_valid <= 1'b0;
      end
    end
  end

  // First-word-fall-through output register; holds steady while stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data  <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
    end else begin
      if (out_load) begin
        out_data  <= ram_q;
        out_valid <= 1'b1;
      end else if (rd_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Fill count, batch-ready hysteresis and sticky overflow (a drop beats a clear).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill        <= CNT_ZERO;
      batch_ready <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      fill        <= fill_next;
      batch_ready <= batch_ready_next;
      if (wr_drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow <= 1'b0;
      end
    end
  end

  assign ram_read_data_o    = out_data;
  assign ram_read_valid_o   = out_valid;
  assign ram_buffer_ready_o = batch_ready;
  assign fill_o             = fill;
  assign overflow_o         = overflow;

endmodule

// File: tb/tb_sample_ram_buffer.sv
// Bench for sample_ram_buffer: two instances (right and left channel) share
// stimulus; a queue-based reference model predicts fill, flags and output
// timing, and a scoreboard checks every transfer in order.
module tb_sample_ram_buffer;

  localparam int DW    = 24;
  localparam int DEPTH = 512;
  localparam int RL    = 256;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] left_s = '0;
  logic [DW-1:0] right_s = '0;
  logic          ovf_clr = 1'b0;
  logic          rd_ready = 1'b0;

  logic [DW-1:0] data_r, data_l;
  logic          valid_r, valid_l, brdy_r, brdy_l, ovf_r, ovf_l;
  logic [FW-1:0] fill_r, fill_l;

  always #5 clk_i = ~clk_i;

  sample_ram_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .READY_LEVEL(RL), .SELECT_LEFT(1'b0)) u_right (
    .clk_i(clk_i), .rst_i(rst_i), .sample_valid_i(sample_valid),
    .left_sample_i(left_s), .right_sample_i(right_s), .ovf_clr_i(ovf_clr),
    .ram_read_data_o(data_r), .ram_read_valid_o(valid_r), .ram_read_ready_i(rd_ready),
    .ram_buffer_ready_o(brdy_r), .fill_o(fill_r), .overflow_o(ovf_r));

  sample_ram_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .READY_LEVEL(RL), .SELECT_LEFT(1'b1)) u_left (
    .clk_i(clk_i), .rst_i(rst_i), .sample_valid_i(sample_valid),
    .left_sample_i(left_s), .right_sample_i(right_s), .ovf_clr_i(ovf_clr),
    .ram_read_data_o(data_l), .ram_read_valid_o(valid_l), .ram_read_ready_i(rd_ready),
    .ram_buffer_ready_o(brdy_l), .fill_o(fill_l), .overflow_o(ovf_l));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted samples as {left,right}, with the edge count at which each was accepted.
  logic [2*DW-1:0] sb_q[$];
  int              acc_q[$];
  int              cyc;
  int              mfill;
  bit              movf;
  bit              mrdy;
  bit              run_chk = 1'b0;

  // Model update on every clock edge; reset empties it.
  always @(posedge clk_i or posedge rst_i) begin : model
    int m;
    int nf;
    bit xfer;
    bit acc;
    bit drop;
    if (rst_i) begin
      acc_q.delete();
      cyc   <= 0;
      mfill <= 0;
      movf  <= 1'b0;
      mrdy  <= 1'b0;
    end else begin
      m    = cyc;
      // A sample is visible two edges after acceptance, and only once it reaches the head.
      xfer = (acc_q.size() > 0) && (acc_q[0] <= m - 2) && rd_ready;
      acc  = sample_valid && (mfill < DEPTH);
      drop = sample_valid && (mfill >= DEPTH);
      if (xfer) void'(acc_q.pop_front());
      if (acc) begin
        acc_q.push_back(m + 1);
        sb_q.push_back({left_s, right_s});
      end
      nf = mfill + (acc ? 1 : 0) - (xfer ? 1 : 0);
      mfill <= nf;
      cyc   <= m + 1;
      if (nf >= RL) mrdy <= 1'b1;
      else if (nf == 0) mrdy <= 1'b0;
      if (drop) movf <= 1'b1;
      else if (ovf_clr) movf <= 1'b0;
    end
  end

  // Scoreboard monitor: pops and compares on every DUT transfer.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_q.delete();
    end else if (valid_r && rd_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL xfer_unexpected: got transfer of %0h expected no data at %0t", data_r, $time);
      end else begin
        check("xfer_data_right", data_r, sb_q[0][DW-1:0]);
        check("xfer_data_left", data_l, sb_q[0][2*DW-1:DW]);
        void'(sb_q.pop_front());
      end
    end
  end

  // Per-cycle comparison of flags, fill and presented data against the model.
  always @(negedge clk_i) begin : cyc_chk
    bit ev;
    if (run_chk && !rst_i) begin
      ev = (acc_q.size() > 0) && (acc_q[0] <= cyc - 2);
      check("fill_r", fill_r, mfill);
      check("fill_l", fill_l, mfill);
      check("ovf_r", ovf_r, movf);
      check("ovf_l", ovf_l, movf);
      check("bufrdy_r", brdy_r, mrdy);
      check("bufrdy_l", brdy_l, mrdy);
      check("valid_r", valid_r, ev);
      check("valid_l", valid_l, ev);
      if (ev && sb_q.size() > 0) begin
        check("head_right", data_r, sb_q[0][DW-1:0]);
        check("head_left", data_l, sb_q[0][2*DW-1:DW]);
      end
    end
  end

  function automatic logic [DW-1:0] rnd_sample();
    logic [DW-1:0] s;
    case ($urandom_range(0, 3))
      0:       s = 24'hFFFFFF;
      1:       s = 24'h800000;
      default: s = DW'($urandom);
    endcase
    return s;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_data_r"}, data_r, 0);
    check({tag, "_valid_r"}, valid_r, 0);
    check({tag, "_bufrdy_r"}, brdy_r, 0);
    check({tag, "_fill_r"}, fill_r, 0);
    check({tag, "_ovf_r"}, ovf_r, 0);
    check({tag, "_data_l"}, data_l, 0);
    check({tag, "_valid_l"}, valid_l, 0);
    check({tag, "_fill_l"}, fill_l, 0);
  endtask

  initial begin
    // Power-on reset
    #1 rst_i = 1'b1;
    #2 check_all_zero("por");
    repeat (3) @(negedge clk_i);
    rst_i   = 1'b0;
    run_chk = 1'b1;
    @(negedge clk_i);

    // Scenario 1: latency and hysteresis, ready low
    rd_ready = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      sample_valid = 1'b1;
      right_s      = DW'(i);
      left_s       = ~DW'(i);
      @(negedge clk_i);
      if (i == 2) check("lat_not_yet", valid_r, 0);
      if (i == 3) begin
        check("lat_valid", valid_r, 1);
        check("lat_data", data_r, 24'h000001);
      end
      if (i == 255) check("bufrdy_before", brdy_r, 0);
    end
    check("bufrdy_set", brdy_r, 1);
    check("fill_256", fill_r, 256);
    sample_valid = 1'b0;
    @(negedge clk_i);

    // Scenario 2: full-rate drain
    rd_ready = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk_i);
      if (i == 255) begin
        check("drain_fill_1", fill_r, 1);
        check("drain_rdy_hold", brdy_r, 1);
      end
    end
    check("drain_fill_0", fill_r, 0);
    check("drain_rdy_clr", brdy_r, 0);
    rd_ready = 1'b0;

    // Scenario 3: overflow with ready low
    for (int i = 0; i < DEPTH + 3; i++) begin
      sample_valid = 1'b1;
      right_s      = rnd_sample();
      left_s       = rnd_sample();
      @(negedge clk_i);
    end
    sample_valid = 1'b0;
    @(negedge clk_i);
    check("ovf_fill_full", fill_r, DEPTH);
    check("ovf_set", ovf_r, 1);

    // Scenario 5: write and read on the same edge while full
    sample_valid = 1'b1;
    right_s      = 24'h123456;
    left_s       = 24'h654321;
    rd_ready     = 1'b1;
    @(negedge clk_i);
    sample_valid = 1'b0;
    rd_ready     = 1'b0;
    check("full_rw_fill", fill_r, DEPTH - 1);
    check("full_rw_ovf", ovf_r, 1);
    @(negedge clk_i);

    // Drain everything, then clear the flag
    rd_ready = 1'b1;
    repeat (DEPTH + 4) @(negedge clk_i);
    check("ovf_drained", fill_r, 0);
    ovf_clr = 1'b1;
    @(negedge clk_i);
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf_r, 0);

    // Scenario 4: alternating ready, one write every 4 cycles, >3 pointer wraps
    for (int c = 0; c < 6400; c++) begin
      rd_ready     = c[0];
      sample_valid = (c % 4 == 0);
      right_s      = rnd_sample();
      left_s       = rnd_sample();
      @(negedge clk_i);
    end
    sample_valid = 1'b0;
    rd_ready     = 1'b1;
    repeat (20) @(negedge clk_i);
    check("alt_drained", fill_r, 0);
    rd_ready = 1'b0;

    // Scenario 6: asynchronous reset with 10 samples stored
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      right_s      = rnd_sample();
      left_s       = rnd_sample();
      @(negedge clk_i);
    end
    sample_valid = 1'b0;
    repeat (3) @(negedge clk_i);
    check("pre_rst_fill", fill_r, 10);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    sample_valid = 1'b1;
    right_s      = 24'h5A5A5A;
    left_s       = 24'hA5A5A5;
    @(negedge clk_i);
    sample_valid = 1'b0;
    @(negedge clk_i);
    check("post_rst_not_yet", valid_r, 0);
    @(negedge clk_i);
    check("post_rst_valid", valid_r, 1);
    check("post_rst_right", data_r, 24'h5A5A5A);
    check("post_rst_left", data_l, 24'hA5A5A5);
    rd_ready = 1'b1;
    repeat (4) @(negedge clk_i);
    check("post_rst_empty", fill_r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
